// File: rtl/ethernet_frame_arbiter_n.sv
// ethernet_frame_arbiter_n
// Frame-granular N-to-1 AXI4-Stream arbiter for the switch egress path.
// Merges NUM_CHANNELS per-class frame streams into one registered output
// stream that feeds the rear egress FIFO. Arbitration is run-time selectable:
// strict priority (highest index wins) or round-robin. A grant is held for a
// whole frame and is never preempted.
//
// Ports:
//   clk                  rising-edge clock
//   rstn                 asynchronous active-low reset
//   arb_mode             0 = strict priority, 1 = round-robin (sampled at grant)
//   ch_enable            per-channel eligibility mask for new grants
//   fifo_is_almost_full  blocks new grants while high
//   s_axis_*             flattened per-channel input streams
//   m_axis_*             registered output stream
//   grant_idx            channel currently or most recently granted
//   busy                 high while a frame is being forwarded
module ethernet_frame_arbiter_n #(
   parameter int NUM_CHANNELS = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
   parameter int IDX_WIDTH    = $clog2(NUM_CHANNELS)
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             arb_mode,
   input  logic [NUM_CHANNELS-1:0]          ch_enable,
   input  logic                             fifo_is_almost_full,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [NUM_CHANNELS-1:0]          s_axis_tvalid,
   output logic [NUM_CHANNELS-1:0]          s_axis_tready,
   input  logic [NUM_CHANNELS-1:0]          s_axis_tlast,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,
   output logic [IDX_WIDTH-1:0]             grant_idx,
   output logic                             busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;
   localparam int         CW      = IDX_WIDTH + 1;

   logic [0:0]            state_reg;
   logic                  mode_reg;
   logic [IDX_WIDTH-1:0]  grant_reg;
   logic [IDX_WIDTH-1:0]  rr_ptr_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [KEEP_WIDTH-1:0] keep_reg;
   logic                  last_reg;
   logic                  valid_reg;

   logic [DATA_WIDTH-1:0] ch_data [NUM_CHANNELS];
   logic [KEEP_WIDTH-1:0] ch_keep [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] elig;
   logic                  out_ready;
   logic                  accept;
   logic                  grant_start;
   logic [IDX_WIDTH-1:0]  sp_sel;
   logic [IDX_WIDTH-1:0]  rr_sel;
   logic [IDX_WIDTH-1:0]  win_sel;
   logic [CW-1:0]         cand;

   assign elig      = s_axis_tvalid & ch_enable;
   // Output slot can take a beat when empty or when it drains this cycle.
   assign out_ready = !valid_reg || m_axis_tready;
   assign accept    = (state_reg == ST_BUSY) && s_axis_tvalid[grant_reg] && out_ready;
   assign grant_start = (state_reg == ST_IDLE) && (|elig) && !fifo_is_almost_full;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
         assign ch_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
         assign ch_keep[gi] = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
         assign s_axis_tready[gi] = (state_reg == ST_BUSY) &&
                                    (grant_reg == IDX_WIDTH'(gi)) && out_ready;
      end
   endgenerate

   // Winner selection. In both loops the last assignment wins, so the strict
   // loop climbs to the highest index and the round-robin loop walks offsets
   // downward so the closest offset after rr_ptr is the one that sticks.
   always_comb begin
      sp_sel = '0;
      rr_sel = '0;
      cand   = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         if (elig[k]) sp_sel = IDX_WIDTH'(k);
      end
      for (int o = NUM_CHANNELS; o >= 1; o--) begin
         cand = {1'b0, rr_ptr_reg} + CW'(o);
         if (cand >= CW'(NUM_CHANNELS)) cand = cand - CW'(NUM_CHANNELS);
         if (elig[cand[IDX_WIDTH-1:0]]) rr_sel = cand[IDX_WIDTH-1:0];
      end
      win_sel = arb_mode ? rr_sel : sp_sel;
   end

   // Control FSM: grant in IDLE, forward one frame in BUSY.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg  <= ST_IDLE;
         mode_reg   <= 1'b0;
         grant_reg  <= '0;
         rr_ptr_reg <= IDX_WIDTH'(NUM_CHANNELS - 1);
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (grant_start) begin
                  grant_reg <= win_sel;
                  mode_reg  <= arb_mode;   // mode of this frame decides rr_ptr update
                  state_reg <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (accept && s_axis_tlast[grant_reg]) begin
                  state_reg <= ST_IDLE;
                  if (mode_reg) rr_ptr_reg <= grant_reg;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Output register slice.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_reg  <= '0;
         keep_reg  <= '0;
         last_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else if (accept) begin
         data_reg  <= ch_data[grant_reg];
         keep_reg  <= ch_keep[grant_reg];
         last_reg  <= s_axis_tlast[grant_reg];
         valid_reg <= 1'b1;
      end else if (m_axis_tready) begin
         valid_reg <= 1'b0;
      end
   end

   assign m_axis_tdata  = data_reg;
   assign m_axis_tkeep  = keep_reg;
   assign m_axis_tlast  = last_reg;
   assign m_axis_tvalid = valid_reg;
   assign grant_idx     = grant_reg;
   assign busy          = (state_reg == ST_BUSY);

endmodule

// File: doc/ethernet_frame_arbiter_n.md
# ethernet_frame_arbiter_n

Frame-granular N-to-1 AXI4-Stream arbiter for the switch egress path. It merges `NUM_CHANNELS` per-class frame streams into one output stream feeding the rear egress FIFO. Arbitration is selectable at run time between strict priority and round-robin. A grant is held for a whole frame, new grants are gated by per-channel enables and by the rear FIFO almost-full flag, and the output is registered.

## Interface
- `NUM_CHANNELS`, 8: number of input streams, 2..16.
- `DATA_WIDTH`, 8: tdata width in bits, a multiple of 8.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width.
- `IDX_WIDTH`, `$clog2(NUM_CHANNELS)`: grant index width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `arb_mode`  in  1  0 = strict priority, higher index wins; 1 = round-robin. Sampled only in IDLE.
- `ch_enable`  in  NUM_CHANNELS  per-channel eligibility mask for new grants.
- `fifo_is_almost_full`  in  1  while high, no new frame is granted.
- `s_axis_tdata`  in  NUM_CHANNELS*DATA_WIDTH  flattened; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tkeep`  in  NUM_CHANNELS*KEEP_WIDTH  flattened, same layout.
- `s_axis_tvalid`  in  NUM_CHANNELS  per channel.
- `s_axis_tready`  out  NUM_CHANNELS  per channel.
- `s_axis_tlast`  in  NUM_CHANNELS  per channel.
- `m_axis_tdata`  out  DATA_WIDTH  registered.
- `m_axis_tkeep`  out  KEEP_WIDTH  registered.
- `m_axis_tvalid`  out  1  registered.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  registered.
- `grant_idx`  out  IDX_WIDTH  index of the channel currently granted or last granted.
- `busy`  out  1  high while in BUSY.

## Operation
- The FSM has two states: IDLE and BUSY. Reset enters IDLE.
- A channel is eligible when `s_axis_tvalid[k] & ch_enable[k]` is true.
- **IDLE:**
  - A grant is issued when any channel is eligible and `fifo_is_almost_full`=0.
  - On a grant, `grant_idx` is registered and the FSM moves to BUSY on the next cycle.
  - All `s_axis_tready` are 0 in IDLE.
- **Strict priority** (`arb_mode`=0): the highest eligible index wins.
- **Round-robin** (`arb_mode`=1):
  - The search starts at `rr_ptr+1` and wraps modulo NUM_CHANNELS; the first eligible channel wins.
  - `rr_ptr` is loaded with the granted index when that frame's tlast beat is accepted.
  - `rr_ptr` resets to NUM_CHANNELS-1, so the first round-robin search starts at channel 0.
  - `rr_ptr` is not updated by strict-priority grants.
- **BUSY:**
  - `s_axis_tready[grant_idx]` = `!m_axis_tvalid | m_axis_tready`. All other tready bits are 0.
  - An accepted input beat loads the output register: tdata, tkeep, tlast, and tvalid=1.
  - When the output beat is taken with no new input beat, tvalid clears.
  - Acceptance of an input beat with tlast=1 moves the FSM to IDLE.
- A grant lasts one whole frame and is never preempted:
  - Deasserting `ch_enable` or asserting `fifo_is_almost_full` mid-frame does not stop the frame.
  - A higher-priority channel becoming valid mid-frame does not stop it either.
- Frames pass through unmodified. tkeep is passed as-is and is not checked.
- The block never drops frames.

## Timing
- Reset values (asynchronous): `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `m_axis_tlast`=0, `s_axis_tready`=0, `grant_idx`=0, `busy`=0, `rr_ptr`=NUM_CHANNELS-1.
- Arbitration takes one cycle:
  - Eligible in cycle t (IDLE) → `busy`=1 and tready asserted in cycle t+1.
  - The first beat is accepted at t+1 at the earliest, and `m_axis_tvalid` rises at t+2.
- Latency from input handshake to output valid is 1 cycle.
- Throughput inside a frame is 1 beat per cycle while `m_axis_tready`=1.
- Between frames there is exactly one IDLE cycle, during which the output register may still drain its last beat.
- `m_axis_tready` to `s_axis_tready` is a combinational path. This is allowed.
- Output stability: while `m_axis_tvalid`=1 and `m_axis_tready`=0, all `m_axis_*` signals hold.
- Input stability: input tvalid/tdata must be held by the source per AXI4-Stream. The block does not sample a channel that is not granted.
- `fifo_is_almost_full` high in the same cycle that a channel becomes eligible → no grant in that cycle. The grant happens in the first IDLE cycle with the flag low.
- Single-beat frame (tlast on the first beat): BUSY lasts exactly 1 accept cycle, then IDLE.
- Reset mid-frame: the output register is cleared and the partial frame is lost. The FSM enters IDLE, and after reset the source must restart from a frame boundary.

## Test plan
- Strict priority, N=8, `ch_enable`=8'hFF: channels 0, 3 and 7 each hold one 64-byte frame. Output order must be ch7, ch3, ch0. Each frame's data must be byte-exact, with exactly 1 IDLE cycle between frames.
- Round-robin: all 8 channels continuously hold frames. Grants must be 0,1,…,7,0. After an 8-frame window, no channel may be more than one frame ahead of any other.
- Back-pressure: `m_axis_tready` toggles pseudo-randomly at 50% across 1000 frames from the pcap source. The output must match the pcap exactly: no loss, no duplication, and the output held stable while stalled.
- Gating: `fifo_is_almost_full`=1 for 20 cycles with ch2 valid → `busy` must stay 0. The grant comes 1 cycle after the flag falls. Asserting the flag mid-frame must not truncate the frame.
- Enable mask: `ch_enable`=8'b0000_0101 with all channels valid → only ch0 and ch2 are granted. Clearing ch2's enable mid-frame → the current frame must still complete with its tlast.
- Reset during a frame at beat 10: every output must take its reset value within the reset cycle. The next frame after reset must pass cleanly.
